// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD byte path: byte width, the handful of panel
// command opcodes the requesters emit, RS/DC line encodings, the arbiter state
// type and a helper that sizes the stall counter.
// No ports (package).
// -----------------------------------------------------------------------------
package lcd_pkg;

    localparam int BYTE_W = 8;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arbState_e;

    // The stall counter must hold the release threshold and is never
    // narrower than a byte, so small thresholds still get a sane counter.
    function automatic int stallWidth(input int maxCount);
        int w;
        w = $clog2(maxCount + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority encoder used to pick the next bus owner.
// Ports:
//   req     in  NREQ   : request vector
//   ptr     in  IDX_W  : index of the previous winner (rotating mode)
//   fixed   in  1      : 1 = lowest index wins, 0 = search from ptr+1
//   win     out NREQ   : one-hot winner, zero when no request
//   win_idx out IDX_W  : binary index of the winner
// -----------------------------------------------------------------------------
module rr_pick
    import lcd_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             fixed,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx
);

    int               cand;
    logic [IDX_W-1:0] candIdx;
    logic             found;

    // Walk the requesters in priority order and keep the first one that is
    // requesting. In rotating mode the walk begins just after the previous
    // winner so that every requester gets a turn.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (fixed) begin
                cand = k;
            end else begin
                cand = (int'(ptr) + 1 + k) % NREQ;
            end
            candIdx = IDX_W'(cand);
            if (!found && req[candIdx]) begin
                found        = 1'b1;
                win[candIdx] = 1'b1;
                win_idx      = candIdx;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_bus_arbiter
// Packet-granular arbiter sharing one LCD byte serializer among NREQ byte
// stream requesters. An owner keeps the bus from its first byte through the
// byte flagged last, so command parameters and pixel bursts stay contiguous.
// Ports:
//   clk        in  1        : serializer clock
//   reset      in  1        : asynchronous, active-high reset
//   req_valid  in  NREQ     : requester i has a byte
//   req_data   in  8*NREQ   : byte of requester i in [8i+7:8i]
//   req_rs     in  NREQ     : RS/DC of that byte (0 command, 1 data)
//   req_last   in  NREQ     : byte ends the packet
//   req_ready  out NREQ     : byte of requester i accepted this cycle
//   grant      out NREQ     : one-hot owner, or zero
//   ser_data   out 8        : byte to the serializer
//   ser_rs     out 1        : RS/DC, held until the next launch
//   ser_irdy   out 1        : ser_data is valid
//   ser_ordy   in  1        : serializer takes the byte when ser_irdy is high
//   busy       out 1        : grant held or output register full
//   stall_err  out 1        : one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int FIXED_PRIO = 0,
    parameter int STALL_MAX  = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_rs,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          grant,
    output logic [BYTE_W-1:0]        ser_data,
    output logic                     ser_rs,
    output logic                     ser_irdy,
    input  logic                     ser_ordy,
    output logic                     busy,
    output logic                     stall_err
);

    localparam int                 IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int                 STALL_W   = stallWidth(STALL_MAX);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

    arbState_e            state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 stallErr_q, stallErr_d;
    logic [BYTE_W-1:0]    serData_q, serData_d;
    logic                 serRs_q, serRs_d;
    logic                 serIrdy_q, serIrdy_d;

    logic [NREQ-1:0]      pickWin;
    logic [IDX_W-1:0]     pickIdx;
    logic                 ownValid;
    logic [BYTE_W-1:0]    ownData;
    logic                 ownRs;
    logic                 ownLast;
    logic                 outRoom;
    logic                 accept;
    logic                 launch;
    logic [STALL_W-1:0]   stallInc;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .fixed   (FIXED_PRIO != 0),
        .win     (pickWin),
        .win_idx (pickIdx)
    );

    // Select the current owner's byte stream. grant_q is one-hot or zero, so
    // at most one iteration matches.
    always_comb begin
        ownValid = 1'b0;
        ownData  = '0;
        ownRs    = RS_CMD;
        ownLast  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                ownValid = req_valid[i];
                ownData  = req_data[i*BYTE_W +: BYTE_W];
                ownRs    = req_rs[i];
                ownLast  = req_last[i];
            end
        end
    end

    // A byte can be taken whenever the output register is empty or is being
    // launched this very cycle; the latter gives back-to-back bytes.
    always_comb begin
        outRoom   = ~serIrdy_q | ser_ordy;
        req_ready = '0;
        if (state_q == ARB_XFER) begin
            req_ready = grant_q & req_valid & {NREQ{outRoom}};
        end
        accept = |req_ready;
        launch = serIrdy_q & ser_ordy;
    end

    // Output register: refill on every accepted byte, otherwise empty it once
    // the serializer has taken the byte. Data and RS are left untouched on a
    // launch so ser_rs stays put until the next accepted byte.
    always_comb begin
        serData_d = serData_q;
        serRs_d   = serRs_q;
        serIrdy_d = serIrdy_q;
        if (accept) begin
            serData_d = ownData;
            serRs_d   = ownRs;
            serIrdy_d = 1'b1;
        end else if (launch) begin
            serIrdy_d = 1'b0;
        end
    end

    // Arbitration FSM. IDLE registers the picked winner; XFER holds the grant
    // until the last byte is accepted or the owner has gone quiet for
    // STALL_MAX cycles. The stall check looks at the incremented value so the
    // release lands STALL_MAX+1 cycles after the owner's last activity.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        stall_d    = stall_q;
        stallErr_d = 1'b0;
        stallInc   = (stall_q == '1) ? stall_q : stall_q + 1'b1;
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    state_d = ARB_XFER;
                    grant_d = pickWin;
                    ptr_d   = pickIdx;
                    stall_d = '0;
                end
            end
            ARB_XFER: begin
                if (accept) begin
                    stall_d = '0;
                    if (ownLast) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end else if (!ownValid) begin
                    stall_d = stallInc;
                    if (stallInc >= STALL_LIM) begin
                        state_d    = ARB_IDLE;
                        grant_d    = '0;
                        stall_d    = '0;
                        stallErr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers. Reset points ptr at the top requester so the first
    // rotating search starts at requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(NREQ - 1);
            stall_q    <= '0;
            stallErr_q <= 1'b0;
            serData_q  <= '0;
            serRs_q    <= RS_DATA;
            serIrdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            stall_q    <= stall_d;
            stallErr_q <= stallErr_d;
            serData_q  <= serData_d;
            serRs_q    <= serRs_d;
            serIrdy_q  <= serIrdy_d;
        end
    end

    assign grant     = grant_q;
    assign ser_data  = serData_q;
    assign ser_rs    = serRs_q;
    assign ser_irdy  = serIrdy_q;
    assign stall_err = stallErr_q;
    assign busy      = (state_q == ARB_XFER) | serIrdy_q;

endmodule
